branch_resolve_unit: RTL and testbench

//  EX-side companion to the BTB. Queues each fetch-stage BTB prediction in order, pops it when the instruction resolves in EX, and detects misprediction.

---
 rtl/branch_resolve_unit_pkg.sv | 20 ++
 rtl/branch_resolve_unit_if.sv | 48 ++++
 rtl/branch_resolve_unit_pred_queue.sv | 53 +++++
 rtl/branch_resolve_unit.sv | 105 ++++++++++
 tb/tb_branch_resolve_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: PC width, queued prediction entry, PC increment.
package branch_resolve_unit_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t PC_INC = 32'd4;

  typedef struct packed {
    pc_t  pc;
    logic pred_taken;
    pc_t  pred_target;
  } pred_entry_t;

  function automatic pc_t next_pc(input pc_t pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX/BTB-update bundle for the branch resolve unit; master = pipeline, slave = unit.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic             if_valid;
  pc_t              if_pc;
  logic             if_pred_taken;
  pc_t              if_pred_target;
  logic             if_stall;

  logic             ex_valid;
  pc_t              ex_pc;
  logic             ex_is_branch;
  logic             ex_taken;
  pc_t              ex_target;

  logic             flush;
  pc_t              redirect_pc;

  logic             btb_update;
  pc_t              btb_update_pc;
  pc_t              btb_update_target;
  logic             btb_mispredicted;

  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             order_error;

  modport master (
    output if_valid, if_pc, if_pred_taken, if_pred_target,
    output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
    input  if_stall, flush, redirect_pc,
    input  btb_update, btb_update_pc, btb_update_target, btb_mispredicted,
    input  branch_count, mispredict_count, order_error
  );

  modport slave (
    input  if_valid, if_pc, if_pred_taken, if_pred_target,
    input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
    output if_stall, flush, redirect_pc,
    output btb_update, btb_update_pc, btb_update_target, btb_mispredicted,
    output branch_count, mispredict_count, order_error
  );

endinterface

// File: rtl/branch_resolve_unit_pred_queue.sv
// In-order prediction FIFO with extended pointers; clear resets both pointers and wins over push/pop.
// Head reads as all-zero (not-taken) while empty.
module pred_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pred_entry_t push_dat,
  input  logic        pop,
  input  logic        clear,
  output pred_entry_t head_dat,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  pred_entry_t mem [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-side BTB companion: resolves queued predictions, drives flush/redirect, registered BTB update and counters.
// Flush is combinational in the resolve cycle; BTB update lands one cycle later.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pred_entry_t      head;
  pred_entry_t      push_dat;
  logic             q_full;
  logic             q_empty;
  logic             push;
  logic             pop;
  logic             mispredict;
  logic             flush_i;
  logic             br_resolve;
  logic             alias_hit;

  logic             upd_q;
  logic             upd_misp_q;
  pc_t              upd_pc_q;
  pc_t              upd_tgt_q;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mp_cnt;
  logic             oerr_q;

  assign push_dat = '{pc: bus.if_pc, pred_taken: bus.if_pred_taken, pred_target: bus.if_pred_target};
  assign push     = bus.if_valid & ~q_full & ~flush_i;
  assign pop      = bus.ex_valid & ~q_empty;

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .clear    (flush_i),
    .head_dat (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // A non-branch predicted taken means the BTB aliased onto it.
  always_comb begin
    mispredict = 1'b0;
    if (bus.ex_is_branch)
      mispredict = (bus.ex_taken != head.pred_taken) ||
                   (bus.ex_taken && (bus.ex_target != head.pred_target));
    else
      mispredict = head.pred_taken;
  end

  assign flush_i    = bus.ex_valid & mispredict;
  assign br_resolve = bus.ex_valid & bus.ex_is_branch;
  assign alias_hit  = bus.ex_valid & ~bus.ex_is_branch & mispredict;

  assign bus.if_stall    = q_full;
  assign bus.flush       = flush_i;
  assign bus.redirect_pc = !flush_i     ? '0 :
                           bus.ex_taken ? bus.ex_target : next_pc(bus.ex_pc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_q      <= 1'b0;
      upd_misp_q <= 1'b0;
      upd_pc_q   <= '0;
      upd_tgt_q  <= '0;
    end else begin
      upd_q      <= br_resolve | alias_hit;
      upd_misp_q <= flush_i & (br_resolve | alias_hit);
      upd_pc_q   <= (br_resolve | alias_hit) ? bus.ex_pc : '0;
      upd_tgt_q  <= br_resolve ? bus.ex_target :
                    alias_hit  ? next_pc(bus.ex_pc) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
      oerr_q <= 1'b0;
    end else begin
      if (br_resolve && (br_cnt != '1)) br_cnt <= br_cnt + CNT_ONE;
      if (flush_i && (mp_cnt != '1))    mp_cnt <= mp_cnt + CNT_ONE;
      if (bus.ex_valid && (q_empty || (bus.ex_pc != head.pc))) oerr_q <= 1'b1;
    end
  end

  assign bus.btb_update        = upd_q;
  assign bus.btb_update_pc     = upd_pc_q;
  assign bus.btb_update_target = upd_tgt_q;
  assign bus.btb_mispredicted  = upd_misp_q;
  assign bus.branch_count      = br_cnt;
  assign bus.mispredict_count  = mp_cnt;
  assign bus.order_error       = oerr_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench: directed scenarios plus random traffic against a queue-based reference model; two DUTs (32- and 4-bit counters).
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_valid = 0, if_pred_taken = 0, ex_valid = 0, ex_is_branch = 0, ex_taken = 0;
  logic [31:0] if_pc = 0, if_pred_target = 0, ex_pc = 0, ex_target = 0;

  branch_resolve_unit_if #(.CNT_W(32)) bus_a ();
  branch_resolve_unit_if #(.CNT_W(4))  bus_b ();

  assign bus_a.if_valid = if_valid;         assign bus_b.if_valid = if_valid;
  assign bus_a.if_pc = if_pc;               assign bus_b.if_pc = if_pc;
  assign bus_a.if_pred_taken = if_pred_taken;   assign bus_b.if_pred_taken = if_pred_taken;
  assign bus_a.if_pred_target = if_pred_target; assign bus_b.if_pred_target = if_pred_target;
  assign bus_a.ex_valid = ex_valid;         assign bus_b.ex_valid = ex_valid;
  assign bus_a.ex_pc = ex_pc;               assign bus_b.ex_pc = ex_pc;
  assign bus_a.ex_is_branch = ex_is_branch; assign bus_b.ex_is_branch = ex_is_branch;
  assign bus_a.ex_taken = ex_taken;         assign bus_b.ex_taken = ex_taken;
  assign bus_a.ex_target = ex_target;       assign bus_b.ex_target = ex_target;

  branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  branch_resolve_unit #(.DEPTH(4), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct { logic [31:0] pc; bit pt; logic [31:0] tgt; } ent_t;
  ent_t        mq[$];
  bit          m_oerr;
  longint      m_bc, m_mc;
  int          m_bc4, m_mc4;
  int unsigned n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    m_oerr = 0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_upd"},  {63'd0, bus_a.btb_update}, 64'd0);
    check({tag, "_upc"},  {32'd0, bus_a.btb_update_pc}, 64'd0);
    check({tag, "_utgt"}, {32'd0, bus_a.btb_update_target}, 64'd0);
    check({tag, "_umis"}, {63'd0, bus_a.btb_mispredicted}, 64'd0);
    check({tag, "_bc"},   {32'd0, bus_a.branch_count}, 64'd0);
    check({tag, "_mc"},   {32'd0, bus_a.mispredict_count}, 64'd0);
    check({tag, "_oerr"}, {63'd0, bus_a.order_error}, 64'd0);
    check({tag, "_stall"}, {63'd0, bus_a.if_stall}, 64'd0);
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic step(input bit iv, input logic [31:0] ipc, input bit ipt, input logic [31:0] itgt,
                      input bit ev, input logic [31:0] epc, input bit eb, input bit et,
                      input logic [31:0] etgt);
    ent_t h;
    bit empty, full, misp, eu, em;
    logic [31:0] redir, eupc, eut;
    @(negedge clk);
    if_valid = iv; if_pc = ipc; if_pred_taken = ipt; if_pred_target = itgt;
    ex_valid = ev; ex_pc = epc; ex_is_branch = eb; ex_taken = et; ex_target = etgt;
    #1;
    empty = (mq.size() == 0);
    full  = (mq.size() == 4);
    h = empty ? '{pc: 32'd0, pt: 1'b0, tgt: 32'd0} : mq[0];
    misp  = ev && (eb ? ((et != h.pt) || (et && etgt != h.tgt)) : h.pt);
    redir = !misp ? 32'd0 : (et ? etgt : epc + 32'd4);
    check("if_stall", {63'd0, bus_a.if_stall}, {63'd0, full});
    check("flush", {63'd0, bus_a.flush}, {63'd0, misp});
    check("redirect_pc", {32'd0, bus_a.redirect_pc}, {32'd0, redir});
    check("flush_b", {63'd0, bus_b.flush}, {63'd0, misp});
    @(posedge clk);
    #1;
    if (ev && empty) m_oerr = 1;
    if (ev && !empty) begin
      if (epc != h.pc) m_oerr = 1;
      void'(mq.pop_front());
    end
    if (misp) mq.delete();
    else if (iv && !full) mq.push_back('{pc: ipc, pt: ipt, tgt: itgt});
    eu   = ev && (eb || misp);
    em   = eu && misp;
    eupc = eu ? epc : 32'd0;
    eut  = !eu ? 32'd0 : (eb ? etgt : epc + 32'd4);
    if (ev && eb) begin
      m_bc++;
      if (m_bc4 < 15) m_bc4++;
    end
    if (misp) begin
      m_mc++;
      if (m_mc4 < 15) m_mc4++;
    end
    check("btb_update", {63'd0, bus_a.btb_update}, {63'd0, eu});
    check("btb_update_pc", {32'd0, bus_a.btb_update_pc}, {32'd0, eupc});
    check("btb_update_target", {32'd0, bus_a.btb_update_target}, {32'd0, eut});
    check("btb_mispredicted", {63'd0, bus_a.btb_mispredicted}, {63'd0, em});
    check("branch_count", {32'd0, bus_a.branch_count}, m_bc);
    check("mispredict_count", {32'd0, bus_a.mispredict_count}, m_mc);
    check("branch_count4", {60'd0, bus_b.branch_count}, 64'(m_bc4));
    check("mispredict_count4", {60'd0, bus_b.mispredict_count}, 64'(m_mc4));
    check("order_error", {63'd0, bus_a.order_error}, {63'd0, m_oerr});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset while a branch resolves; its registered update must be dropped.
  task automatic mid_reset();
    @(negedge clk);
    if_valid = 1; if_pc = 32'h500; ex_valid = 1; ex_pc = 32'h400; ex_is_branch = 1;
    ex_taken = 0; ex_target = 0;
    #2 rst = 0;
    #1;
    check_all_zero("rst_async");
    check("rst_flush", {63'd0, bus_a.flush}, 64'd0);
    check("rst_redirect", {32'd0, bus_a.redirect_pc}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    if_valid = 0; ex_valid = 0; ex_is_branch = 0;
    rst = 1;
    model_clear();
    @(posedge clk);
    #1;
    check_all_zero("rst_after");
  endtask

  initial begin
    model_clear();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;

    // Reset mid-stream with entries queued
    step(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h404, 1, 32'h40, 0, 0, 0, 0, 0);
    mid_reset();

    // Correct prediction
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 1, 1, 32'h200);
    // Direction miss; younger push suppressed, queue emptied
    step(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h108, 0, 0, 1, 32'h104, 1, 1, 32'h80);
    idle();
    // BTB alias on a non-branch
    step(1, 32'h10C, 1, 32'h300, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h10C, 0, 0, 0);

    // Full queue, blocked 5th push, simultaneous push/pop while full
    for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h210, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h214, 0, 0, 1, 32'h200, 0, 0, 0);
    idle();
    for (int i = 1; i < 4; i++) step(0, 0, 0, 0, 1, 32'h200 + 32'(4 * i), 0, 0, 0);
    idle();

    // Order error is sticky
    step(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h999, 0, 0, 0);
    idle();
    idle();
    // Saturation of the 4-bit counters: mispredicting branches with empty queue
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 32'h600, 1, 1, 32'h700);

    // Randomized traffic
    mid_reset();
    for (int n = 0; n < 400; n++) begin
      bit iv, ipt, ev, eb, et;
      logic [31:0] ipc, itgt, epc, etgt;
      iv   = ($urandom_range(0, 1) == 1);
      ipc  = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      ipt  = ($urandom_range(0, 1) == 1);
      itgt = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
      if (mq.size() != 0) ev = ($urandom_range(0, 2) != 0);
      else                ev = ($urandom_range(0, 7) == 0);
      epc  = (mq.size() != 0 && $urandom_range(0, 15) != 0) ? mq[0].pc : 32'($urandom);
      eb   = ($urandom_range(0, 3) != 0);
      et   = ($urandom_range(0, 1) == 1);
      etgt = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h80;
      if ($urandom_range(0, 99) == 0) mid_reset();
      else step(iv, ipc, ipt, itgt, ev, epc, eb, et, etgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
